// File: rtl/axi_pipeline_throttled.sv
// AXI4 five-channel register pipeline with per-channel depth, outstanding-burst
// throttling on AR/AW, a drain request and a registered idle flag.

module axi_pipeline_throttled_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data,
  output logic         busy
);
  logic         m_valid, s_valid, rdy, s_valid_nxt, push, pop;
  logic [W-1:0] m_data, s_data;

  assign push = up_valid & rdy;
  assign pop  = m_valid & dn_ready;

  // Ready is the registered inverse of skid occupancy, so it never sees up_valid.
  always_comb begin
    s_valid_nxt = s_valid ? ~pop : (push & m_valid & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      if (pop) begin
        if (!s_valid && !push) m_valid <= 1'b0;
      end else if (push && !m_valid) begin
        m_valid <= 1'b1;
      end
      s_valid <= s_valid_nxt;
      rdy     <= ~s_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      if (s_valid)   m_data <= s_data;
      else if (push) m_data <= up_data;
    end else if (push) begin
      if (!m_valid) m_data <= up_data;
      else          s_data <= up_data;
    end
  end

  assign up_ready = rdy;
  assign dn_valid = m_valid;
  assign dn_data  = m_data;
  assign busy     = m_valid | s_valid;
endmodule

module axi_pipeline_throttled_chain #(
  parameter int unsigned W     = 8,
  parameter int unsigned LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data,
  output logic         busy
);
  if (LEVEL == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign dn_valid = up_valid;
    assign up_ready = dn_ready;
    assign dn_data  = up_data;
    assign busy     = 1'b0;
  end else begin : g_stages
    logic [LEVEL:0]        v, r;
    logic [LEVEL:0][W-1:0] d;
    logic [LEVEL-1:0]      b;
    assign v[0]     = up_valid;
    assign d[0]     = up_data;
    assign up_ready = r[0];
    assign dn_valid = v[LEVEL];
    assign dn_data  = d[LEVEL];
    assign r[LEVEL] = dn_ready;
    assign busy     = |b;
    for (genvar g = 0; g < LEVEL; g++) begin : g_st
      axi_pipeline_throttled_stage #(.W(W)) u_stage (
        .clk(clk), .rst_n(rst_n),
        .up_valid(v[g]), .up_ready(r[g]), .up_data(d[g]),
        .dn_valid(v[g+1]), .dn_ready(r[g+1]), .dn_data(d[g+1]),
        .busy(b[g])
      );
    end
  end
endmodule

module axi_pipeline_throttled #(
  parameter int unsigned C_M_AXI_ID_WIDTH    = 8,
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH  = 512,
  parameter int unsigned C_M_AXI_WSTRB_WIDTH = C_M_AXI_DATA_WIDTH / 8,
  parameter int unsigned AW_LEVEL = 2,
  parameter int unsigned W_LEVEL  = 2,
  parameter int unsigned B_LEVEL  = 2,
  parameter int unsigned AR_LEVEL = 2,
  parameter int unsigned R_LEVEL  = 2,
  parameter int unsigned MAX_RD_OUTSTANDING = 16,
  parameter int unsigned MAX_WR_OUTSTANDING = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           drain,
  input  logic                           in_AWVALID,
  output logic                           in_AWREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_AWADDR,
  input  logic [1:0]                     in_AWBURST,
  input  logic [7:0]                     in_AWLEN,
  input  logic [2:0]                     in_AWSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_AWID,
  input  logic                           in_WVALID,
  output logic                           in_WREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  in_WDATA,
  input  logic [C_M_AXI_WSTRB_WIDTH-1:0] in_WSTRB,
  input  logic                           in_WLAST,
  output logic                           in_BVALID,
  input  logic                           in_BREADY,
  output logic [1:0]                     in_BRESP,
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_BID,
  input  logic                           in_ARVALID,
  output logic                           in_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_ARADDR,
  input  logic [1:0]                     in_ARBURST,
  input  logic [7:0]                     in_ARLEN,
  input  logic [2:0]                     in_ARSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_ARID,
  output logic                           in_RVALID,
  input  logic                           in_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  in_RDATA,
  output logic                           in_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_RID,
  output logic [1:0]                     in_RRESP,
  output logic                           out_AWVALID,
  input  logic                           out_AWREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_AWADDR,
  output logic [1:0]                     out_AWBURST,
  output logic [7:0]                     out_AWLEN,
  output logic [2:0]                     out_AWSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_AWID,
  output logic                           out_WVALID,
  input  logic                           out_WREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  out_WDATA,
  output logic [C_M_AXI_WSTRB_WIDTH-1:0] out_WSTRB,
  output logic                           out_WLAST,
  input  logic                           out_BVALID,
  output logic                           out_BREADY,
  input  logic [1:0]                     out_BRESP,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_BID,
  output logic                           out_ARVALID,
  input  logic                           out_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_ARADDR,
  output logic [1:0]                     out_ARBURST,
  output logic [7:0]                     out_ARLEN,
  output logic [2:0]                     out_ARSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_ARID,
  input  logic                           out_RVALID,
  output logic                           out_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  out_RDATA,
  input  logic                           out_RLAST,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_RID,
  input  logic [1:0]                     out_RRESP,
  output logic [CNT_WIDTH-1:0]           rd_outstanding,
  output logic [CNT_WIDTH-1:0]           wr_outstanding,
  output logic                           idle
);
  localparam int unsigned AXW = C_M_AXI_ADDR_WIDTH + 13 + C_M_AXI_ID_WIDTH;
  localparam int unsigned WW  = C_M_AXI_DATA_WIDTH + C_M_AXI_WSTRB_WIDTH + 1;
  localparam int unsigned BW  = 2 + C_M_AXI_ID_WIDTH;
  localparam int unsigned RW  = C_M_AXI_DATA_WIDTH + 3 + C_M_AXI_ID_WIDTH;

  logic           rd_ok, wr_ok, ar_up_ready, aw_up_ready;
  logic           aw_busy, w_busy, b_busy, ar_busy, r_busy;
  logic [AXW-1:0] aw_dn, ar_dn;
  logic [WW-1:0]  w_dn;
  logic [BW-1:0]  b_dn;
  logic [RW-1:0]  r_dn;
  logic [CNT_WIDTH-1:0] rd_cnt, wr_cnt;

  assign rd_ok = (rd_cnt < CNT_WIDTH'(MAX_RD_OUTSTANDING)) & ~drain;
  assign wr_ok = (wr_cnt < CNT_WIDTH'(MAX_WR_OUTSTANDING)) & ~drain;
  assign in_ARREADY = ar_up_ready & rd_ok;
  assign in_AWREADY = aw_up_ready & wr_ok;

  // Throttle gates VALID into the stage so a blocked request never enters it.
  axi_pipeline_throttled_chain #(.W(AXW), .LEVEL(AW_LEVEL)) u_aw (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .up_valid(in_AWVALID & wr_ok), .up_ready(aw_up_ready),
    .up_data({in_AWADDR, in_AWBURST, in_AWLEN, in_AWSIZE, in_AWID}),
    .dn_valid(out_AWVALID), .dn_ready(out_AWREADY), .dn_data(aw_dn), .busy(aw_busy)
  );
  assign {out_AWADDR, out_AWBURST, out_AWLEN, out_AWSIZE, out_AWID} = aw_dn;

  axi_pipeline_throttled_chain #(.W(WW), .LEVEL(W_LEVEL)) u_w (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .up_valid(in_WVALID), .up_ready(in_WREADY), .up_data({in_WDATA, in_WSTRB, in_WLAST}),
    .dn_valid(out_WVALID), .dn_ready(out_WREADY), .dn_data(w_dn), .busy(w_busy)
  );
  assign {out_WDATA, out_WSTRB, out_WLAST} = w_dn;

  axi_pipeline_throttled_chain #(.W(BW), .LEVEL(B_LEVEL)) u_b (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .up_valid(out_BVALID), .up_ready(out_BREADY), .up_data({out_BRESP, out_BID}),
    .dn_valid(in_BVALID), .dn_ready(in_BREADY), .dn_data(b_dn), .busy(b_busy)
  );
  assign {in_BRESP, in_BID} = b_dn;

  axi_pipeline_throttled_chain #(.W(AXW), .LEVEL(AR_LEVEL)) u_ar (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .up_valid(in_ARVALID & rd_ok), .up_ready(ar_up_ready),
    .up_data({in_ARADDR, in_ARBURST, in_ARLEN, in_ARSIZE, in_ARID}),
    .dn_valid(out_ARVALID), .dn_ready(out_ARREADY), .dn_data(ar_dn), .busy(ar_busy)
  );
  assign {out_ARADDR, out_ARBURST, out_ARLEN, out_ARSIZE, out_ARID} = ar_dn;

  axi_pipeline_throttled_chain #(.W(RW), .LEVEL(R_LEVEL)) u_r (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .up_valid(out_RVALID), .up_ready(out_RREADY),
    .up_data({out_RDATA, out_RLAST, out_RID, out_RRESP}),
    .dn_valid(in_RVALID), .dn_ready(in_RREADY), .dn_data(r_dn), .busy(r_busy)
  );
  assign {in_RDATA, in_RLAST, in_RID, in_RRESP} = r_dn;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      idle   <= 1'b0;
    end else begin
      unique case ({in_ARVALID & in_ARREADY, in_RVALID & in_RREADY & in_RLAST})
        2'b10:   if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
        2'b01:   if (rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
        default: ;
      endcase
      unique case ({in_AWVALID & in_AWREADY, in_BVALID & in_BREADY})
        2'b10:   if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        2'b01:   if (wr_cnt != '0) wr_cnt <= wr_cnt - 1'b1;
        default: ;
      endcase
      idle <= (rd_cnt == '0) & (wr_cnt == '0) &
              ~(aw_busy | w_busy | b_busy | ar_busy | r_busy);
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;
endmodule
